// File: rtl/shift_unit_seq.sv
// Multi-cycle barrel shifter: resolves one power-of-two stage per clock, LOG2W cycles per op.
// Start/result-ready handshake; data_result holds between completions.
module shift_unit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ctrl_start,
  input  logic [1:0]               ctrl_op,
  input  logic [WIDTH-1:0]         data_operand,
  input  logic [$clog2(WIDTH)-1:0] data_shamt,
  output logic [WIDTH-1:0]         data_result,
  output logic                     data_resultRDY,
  output logic                     busy
);

  localparam int unsigned LOG2W = $clog2(WIDTH);
  localparam logic [LOG2W-1:0] LastStage = LOG2W'(LOG2W - 1);

  typedef enum logic [1:0] {OpSll = 2'b00, OpSrl = 2'b01, OpSra = 2'b10, OpRol = 2'b11} op_e;
  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [LOG2W-1:0]  k_q, k_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [1:0]        op_q, op_d;
  logic [LOG2W-1:0]  shamt_q, shamt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              rdy_q, rdy_d;
  logic [WIDTH-1:0]  stage_out;
  logic [WIDTH-1:0]  stage_sel;

  // Only one stage is active per cycle; select its constant-distance shift.
  always_comb begin
    stage_out = work_q;
    for (int s = 0; s < LOG2W; s++) begin
      if (k_q == LOG2W'(s)) begin
        unique case (op_e'(op_q))
          OpSll: stage_out = work_q << (2 ** s);
          OpSrl: stage_out = work_q >> (2 ** s);
          OpSra: stage_out = $signed(work_q) >>> (2 ** s);
          OpRol: stage_out = (work_q << (2 ** s)) | (work_q >> (WIDTH - 2 ** s));
        endcase
      end
    end
  end

  assign stage_sel = shamt_q[k_q] ? stage_out : work_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    work_d   = work_q;
    op_d     = op_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          work_d  = data_operand;
          op_d    = ctrl_op;
          shamt_d = data_shamt;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d = stage_sel;
        k_d    = k_q + 1'b1;
        if (k_q == LastStage) begin
          result_d = stage_sel;
          rdy_d    = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      work_q   <= '0;
      op_q     <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      work_q   <= work_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == StRun);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq at WIDTH=32: latency, op semantics, ignore-while-busy,
// back-to-back start, reset abort and input isolation.
module tb_shift_unit_seq;

  localparam logic [1:0] Sll = 2'b00, Srl = 2'b01, Sra = 2'b10, Rol = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [1:0]  ctrl_op;
  logic [31:0] data_operand;
  logic [4:0]  data_shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shift_unit_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_op        (ctrl_op),
    .data_operand   (data_operand),
    .data_shamt     (data_shamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] opnd, input logic [4:0] sh);
    ctrl_start   = 1'b1;
    ctrl_op      = op;
    data_operand = opnd;
    data_shamt   = sh;
  endtask

  // Start an op at the next edge, wait (bounded) for RDY, check latency and result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] opnd,
                        input logic [4:0] sh, input logic [31:0] exp);
    int  cyc;
    bit  seen;
    drive(op, opnd, sh);
    tick();
    ctrl_start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      cyc++;
      if (data_resultRDY) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd5);
    check({tag, "_result"}, data_result, exp);
  endtask

  initial begin
    reset        = 1'b1;
    ctrl_start   = 1'b0;
    ctrl_op      = Sll;
    data_operand = '0;
    data_shamt   = '0;
    tick();
    tick();
    check("reset_result", data_result, 32'h0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // 1. SLL 1 by 31, cycle by cycle
    drive(Sll, 32'h0000_0001, 5'd31);
    tick();
    ctrl_start = 1'b0;
    check("t1_busy_e0", 32'(busy), 32'd1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("t1_busy_e%0d", e), 32'(busy), 32'd1);
      check($sformatf("t1_rdy_e%0d", e), 32'(data_resultRDY), 32'd0);
    end
    tick();
    check("t1_rdy_e5", 32'(data_resultRDY), 32'd1);
    check("t1_busy_e5", 32'(busy), 32'd0);
    check("t1_result", data_result, 32'h8000_0000);
    tick();
    check("t1_rdy_pulse_end", 32'(data_resultRDY), 32'd0);
    check("t1_result_hold", data_result, 32'h8000_0000);

    // 2./3. op semantics
    run_op("sra4", Sra, 32'h8000_00F0, 5'd4, 32'hF800_000F);
    run_op("srl4", Srl, 32'h8000_00F0, 5'd4, 32'h0800_000F);
    run_op("rol1", Rol, 32'h8000_0001, 5'd1, 32'h0000_0003);
    run_op("rol0", Rol, 32'h1234_5678, 5'd0, 32'h1234_5678);
    run_op("sll0", Sll, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    run_op("rol12", Rol, 32'h1234_5678, 5'd12, 32'h4567_8123);
    run_op("sra31_pos", Sra, 32'h7000_0000, 5'd31, 32'h0000_0000);
    run_op("sra31_neg", Sra, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl31", Srl, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);

    // 4. start while busy ignored; start in RDY cycle accepted
    drive(Sll, 32'h0000_0001, 5'd3);
    tick();
    ctrl_start = 1'b0;
    tick();
    drive(Rol, 32'h0000_FFFF, 5'd7);
    tick();
    ctrl_start = 1'b0;
    tick();
    tick();
    tick();
    check("t4_rdy", 32'(data_resultRDY), 32'd1);
    check("t4_result", data_result, 32'h0000_0008);
    drive(Srl, 32'h0000_00F0, 5'd4);
    tick();
    ctrl_start = 1'b0;
    check("t4_b2b_busy", 32'(busy), 32'd1);
    check("t4_b2b_rdy_low", 32'(data_resultRDY), 32'd0);
    for (int e = 1; e <= 4; e++) tick();
    check("t4_b2b_rdy_early", 32'(data_resultRDY), 32'd0);
    tick();
    check("t4_b2b_rdy", 32'(data_resultRDY), 32'd1);
    check("t4_b2b_result", data_result, 32'h0000_000F);

    // 5. reset mid-run aborts; start together with reset is not accepted
    drive(Sll, 32'h0000_0003, 5'd2);
    tick();
    ctrl_start = 1'b0;
    tick();
    reset      = 1'b1;
    ctrl_start = 1'b1;
    tick();
    reset      = 1'b0;
    ctrl_start = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_result", data_result, 32'h0);
    begin
      int rdy_seen = 0;
      for (int e = 0; e < 8; e++) begin
        tick();
        if (data_resultRDY || busy) rdy_seen++;
      end
      check("t5_no_rdy_no_busy", 32'(rdy_seen), 32'd0);
    end
    check("t5_result_hold", data_result, 32'h0);

    // 6. input changes during run do not affect the result
    drive(Srl, 32'hF000_0000, 5'd8);
    tick();
    ctrl_start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      ctrl_op      = Sll;
      data_operand = 32'hFFFF_FFFF - 32'(e);
      data_shamt   = 5'(e);
      tick();
    end
    tick();
    check("t6_rdy", 32'(data_resultRDY), 32'd1);
    check("t6_result", data_result, 32'h00F0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
